// File: rtl/uram_cam_ctrl.sv
// uram_cam_ctrl: software CAM over a simple dual-port UltraRAM-style key table.
// find/add/del are executed as a linear scan of the table, one address per cycle.
//
// Ports:
//   clk_main_a0  clock
//   rst_main_n   asynchronous active-low reset (control state only; RAM is not reset)
//   find/add/del command levels; a rising edge in IDLE starts an operation
//   key          key operand, latched when a command is accepted
//   find_ok      last operation succeeded (sticky)
//   find_ko      last operation failed: miss, table full or illegal command (sticky)
//   busy         initialisation or operation in progress
//   hit_idx      index where the last find/add/del terminated
//   entry_cnt    number of valid entries in the table
module uram_cam_ctrl #(
    parameter  int KEY_W  = 29,
    parameter  int DEPTH  = 4096,
    parameter  int RD_LAT = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic              find,
    input  logic              add,
    input  logic              del,
    input  logic [KEY_W-1:0]  key,
    output logic              find_ok,
    output logic              find_ko,
    output logic              busy,
    output logic [ADDR_W-1:0] hit_idx,
    output logic [ADDR_W:0]   entry_cnt
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN} state_t;
    typedef enum logic [1:0] {OP_FIND, OP_ADD, OP_DEL} op_t;

    state_t state_q, state_d;
    op_t    op_q;

    logic [KEY_W:0]    mem [DEPTH];
    logic              find_q, add_q, del_q;
    logic [2:0]        edges;
    logic              one_edge, multi_edge, accept, illegal;
    logic [ADDR_W-1:0] init_addr_q, scan_addr_q;
    logic              issue_done_q, rd_en;
    logic [KEY_W-1:0]  key_q;
    logic [KEY_W:0]    word_p1, word_p2, cmp_word;
    logic [ADDR_W-1:0] idx_p1, idx_p2, cmp_idx;
    logic              vld_p1, vld_p2, cmp_vld;
    logic              hit, term;
    logic              free_found_q, cur_free;
    logic [ADDR_W-1:0] free_idx_q, cur_free_idx;
    logic              wr_pend_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [KEY_W:0]    wr_word_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [KEY_W:0]    mem_wd;

    assign edges      = {find & ~find_q, add & ~add_q, del & ~del_q};
    assign one_edge   = (edges == 3'b100) || (edges == 3'b010) || (edges == 3'b001);
    assign multi_edge = (edges != 3'b000) && !one_edge;
    assign accept     = (state_q == S_IDLE) && one_edge;
    assign illegal    = (state_q == S_IDLE) && multi_edge;
    assign busy       = (state_q != S_IDLE);

    // Stage p0: issue one read per cycle until the last address has gone out.
    assign rd_en = (state_q == S_SCAN) && !issue_done_q;

    // Compare stage: RAM data after RD_LAT cycles, aligned with its index.
    assign cmp_word = (RD_LAT == 2) ? word_p2 : word_p1;
    assign cmp_idx  = (RD_LAT == 2) ? idx_p2  : idx_p1;
    assign cmp_vld  = (state_q == S_SCAN) && ((RD_LAT == 2) ? vld_p2 : vld_p1);

    assign hit  = cmp_vld && cmp_word[KEY_W] && (cmp_word[KEY_W-1:0] == key_q);
    assign term = hit || (cmp_vld && (cmp_idx == LAST));

    // The entry being compared this cycle counts as a free slot candidate too,
    // so a table whose only hole is the last address still accepts an add.
    assign cur_free     = free_found_q || (cmp_vld && !cmp_word[KEY_W]);
    assign cur_free_idx = free_found_q ? free_idx_q : cmp_idx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_addr_q == LAST) state_d = S_IDLE;
            S_IDLE:  if (accept) state_d = S_SCAN;
            S_SCAN:  if (term) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) state_q <= S_INIT;
        else             state_q <= state_d;
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            find_q       <= 1'b0;
            add_q        <= 1'b0;
            del_q        <= 1'b0;
            init_addr_q  <= '0;
            scan_addr_q  <= '0;
            issue_done_q <= 1'b0;
            op_q         <= OP_FIND;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            free_found_q <= 1'b0;
            find_ok      <= 1'b0;
            find_ko      <= 1'b0;
            hit_idx      <= '0;
            entry_cnt    <= '0;
            wr_pend_q    <= 1'b0;
        end else begin
            // Edge registers always follow the inputs so dropped edges never replay.
            find_q    <= find;
            add_q     <= add;
            del_q     <= del;
            wr_pend_q <= 1'b0;

            if (state_q == S_INIT) init_addr_q <= init_addr_q + ADDR_W'(1);

            if (accept) begin
                op_q         <= edges[2] ? OP_FIND : (edges[1] ? OP_ADD : OP_DEL);
                scan_addr_q  <= '0;
                issue_done_q <= 1'b0;
                free_found_q <= 1'b0;
                find_ok      <= 1'b0;
                find_ko      <= 1'b0;
            end

            if (illegal) begin
                find_ok <= 1'b0;
                find_ko <= 1'b1;
            end

            if (rd_en) begin
                scan_addr_q <= scan_addr_q + ADDR_W'(1);
                if (scan_addr_q == LAST) issue_done_q <= 1'b1;
            end

            // Stage p1/p2: in-flight reads are squashed once the scan terminates.
            vld_p1 <= rd_en && !term;
            vld_p2 <= vld_p1 && !term;

            if (cmp_vld && !cmp_word[KEY_W]) free_found_q <= 1'b1;

            // Completion: results become visible in the following cycle.
            if (term) begin
                hit_idx <= cmp_idx;
                case (op_q)
                    OP_ADD: begin
                        if (hit) begin
                            find_ok <= 1'b1;
                        end else if (cur_free) begin
                            find_ok   <= 1'b1;
                            hit_idx   <= cur_free_idx;
                            wr_pend_q <= 1'b1;
                            if (entry_cnt != FULL) entry_cnt <= entry_cnt + 1'b1;
                        end else begin
                            find_ko <= 1'b1;
                        end
                    end
                    OP_DEL: begin
                        if (hit) begin
                            find_ok   <= 1'b1;
                            wr_pend_q <= 1'b1;
                            if (entry_cnt != '0) entry_cnt <= entry_cnt - 1'b1;
                        end else begin
                            find_ko <= 1'b1;
                        end
                    end
                    default: begin
                        if (hit) find_ok <= 1'b1;
                        else     find_ko <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Datapath registers carry no reset; they are qualified by control state.
    always_ff @(posedge clk_main_a0) begin
        if (accept) key_q <= key;
        word_p1 <= mem[scan_addr_q];
        idx_p1  <= scan_addr_q;
        word_p2 <= word_p1;
        idx_p2  <= idx_p1;
        if (cmp_vld && !cmp_word[KEY_W] && !free_found_q) free_idx_q <= cmp_idx;
        if (term) begin
            wr_addr_q <= (op_q == OP_ADD) ? cur_free_idx : cmp_idx;
            wr_word_q <= {(op_q == OP_ADD), key_q};
        end
    end

    // Write port: INIT clears the table; otherwise the pending add/del write lands
    // in the completion cycle, before any read of a following scan is issued.
    assign mem_we = (state_q == S_INIT) || wr_pend_q;
    assign mem_wa = (state_q == S_INIT) ? init_addr_q : wr_addr_q;
    assign mem_wd = (state_q == S_INIT) ? '0 : wr_word_q;

    always_ff @(posedge clk_main_a0) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

endmodule

// File: tb/tb_uram_cam_ctrl.sv
module tb_uram_cam_ctrl;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b0;
    logic        find = 1'b0, add = 1'b0, del = 1'b0;
    logic [28:0] key = '0;
    logic        find_ok, find_ko, busy;
    logic [2:0]  hit_idx;
    logic [3:0]  entry_cnt;

    int total = 0;
    int bad   = 0;
    logic [28:0] kk [8];

    uram_cam_ctrl #(.KEY_W(29), .DEPTH(8), .RD_LAT(1)) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .find        (find),
        .add         (add),
        .del         (del),
        .key         (key),
        .find_ok     (find_ok),
        .find_ko     (find_ko),
        .busy        (busy),
        .hit_idx     (hit_idx),
        .entry_cnt   (entry_cnt)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_main_a0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a command for one cycle (cycle N); returns in cycle N+1 with the key scrambled.
    task automatic issue(input logic [2:0] m, input logic [28:0] k);
        {find, add, del} = m;
        key = k;
        tick(1);
        {find, add, del} = 3'b000;
        key = ~k;
    endtask

    // Command with completion at N+lat: busy high before, low at completion, then results.
    task automatic run(input string tag, input logic [2:0] m, input logic [28:0] k, input int lat,
                       input int ok, input int ko, input int idx, input int cnt);
        issue(m, k);
        chk({tag, ".busy_n1"}, busy, 1);
        tick(lat - 2);
        chk({tag, ".busy_last"}, busy, 1);
        tick(1);
        chk({tag, ".busy_done"}, busy, 0);
        chk({tag, ".ok"}, find_ok, ok);
        chk({tag, ".ko"}, find_ko, ko);
        chk({tag, ".idx"}, hit_idx, idx);
        chk({tag, ".cnt"}, entry_cnt, cnt);
    endtask

    initial begin
        kk[0] = 29'h0ABCDEF;
        for (int i = 1; i < 8; i++) kk[i] = 29'h1000000 + 29'(i * 29'h111);

        // Reset values while asserted
        tick(3);
        chk("rst.busy", busy, 1);
        chk("rst.ok", find_ok, 0);
        chk("rst.ko", find_ko, 0);
        chk("rst.idx", hit_idx, 0);
        chk("rst.cnt", entry_cnt, 0);

        // Release; a find edge during INIT must be ignored
        rst_main_n = 1'b1;
        tick(3);
        find = 1'b1;
        key  = 29'h0ABCDEF;
        tick(1);
        find = 1'b0;
        tick(3);
        chk("init.busy7", busy, 1);
        tick(1);
        chk("init.busy8", busy, 0);
        chk("init.ok", find_ok, 0);
        chk("init.ko", find_ko, 0);
        chk("init.cnt", entry_cnt, 0);
        tick(2);

        // add to empty table: full scan, lands at slot 0
        run("add0", 3'b010, kk[0], 10, 1, 0, 0, 1);
        run("find0", 3'b100, kk[0], 3, 1, 0, 0, 1);
        run("findmiss", 3'b100, 29'h0001234, 10, 0, 1, 7, 1);

        // Fill the table
        for (int i = 1; i < 8; i++) run("fill", 3'b010, kk[i], 10, 1, 0, i, i + 1);
        run("addfull", 3'b010, 29'h1FFFFFFF, 10, 0, 1, 7, 8);
        run("readd2", 3'b010, kk[2], 5, 1, 0, 2, 8);

        // Delete and reuse the hole
        run("del3", 3'b001, kk[3], 6, 1, 0, 3, 7);
        run("find3", 3'b100, kk[3], 10, 0, 1, 7, 7);
        run("delmiss", 3'b001, 29'h0001234, 10, 0, 1, 7, 7);
        run("addnew", 3'b010, 29'h0777777, 10, 1, 0, 3, 8);

        // Two edges in one cycle: illegal, no table access
        issue(3'b110, 29'h0424242);
        chk("ill.ko", find_ko, 1);
        chk("ill.ok", find_ok, 0);
        chk("ill.busy", busy, 0);
        chk("ill.idx", hit_idx, 3);
        tick(1);
        chk("ill.busy2", busy, 0);
        chk("ill.cnt", entry_cnt, 8);
        run("find5", 3'b100, kk[5], 8, 1, 0, 5, 8);
        run("findill", 3'b100, 29'h0424242, 10, 0, 1, 7, 8);

        // add edge while busy is dropped and never replayed
        issue(3'b100, kk[7]);
        tick(1);
        add = 1'b1;
        key = 29'h0555555;
        tick(1);
        add = 1'b0;
        chk("drop.busy", busy, 1);
        tick(7);
        chk("drop.done", busy, 0);
        chk("drop.ok", find_ok, 1);
        chk("drop.idx", hit_idx, 7);
        tick(4);
        chk("drop.idle", busy, 0);
        chk("drop.ok2", find_ok, 1);
        chk("drop.ko2", find_ko, 0);
        chk("drop.cnt", entry_cnt, 8);

        // Reset in the middle of a del scan
        issue(3'b001, kk[6]);
        tick(2);
        rst_main_n = 1'b0;
        #1;
        chk("mid.busy", busy, 1);
        chk("mid.ok", find_ok, 0);
        chk("mid.ko", find_ko, 0);
        chk("mid.cnt", entry_cnt, 0);
        chk("mid.idx", hit_idx, 0);
        tick(1);
        rst_main_n = 1'b1;
        tick(7);
        chk("reinit.busy7", busy, 1);
        tick(1);
        chk("reinit.busy8", busy, 0);
        tick(1);
        run("post6", 3'b100, kk[6], 10, 0, 1, 7, 0);
        run("post0", 3'b100, kk[0], 10, 0, 1, 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
